// File: rtl/rv32i_types.sv
// Shared instruction-queue types for the issue stage: functional unit
// encoding and the decoded entry presented at the queue head.
package rv32i_types;

  // Default number of functional units in the back end.
  localparam int FU_COUNT = 4;

  // Architectural register index width.
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2,
    FU_BR  = 2'd3
  } fu_type_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 writes_rd;
    fu_type_e             fu_type;
  } iq_entry_t;

endpackage

// File: rtl/reg_status_table.sv
// Scoreboard of architectural registers: a pending bit and the index of the
// functional unit that will produce each register. Completion clears by owner.
module reg_status_table
  import rv32i_types::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_FU   = FU_COUNT,
  localparam int RW      = $clog2(NUM_REGS),
  localparam int OW      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [RW-1:0]     set_reg_i,
  input  logic [OW-1:0]     set_owner_i,
  input  logic [NUM_FU-1:0] clr_mask_i,
  input  logic [RW-1:0]     rs1_i,
  input  logic [RW-1:0]     rs2_i,
  input  logic [RW-1:0]     rd_i,
  output logic              rs1_pend_o,
  output logic              rs2_pend_o,
  output logic              rd_pend_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [OW-1:0]       owner_q [NUM_REGS];
  logic [OW-1:0]       owner_d [NUM_REGS];

  // Next state: clear entries whose owner completed, then apply the new
  // allocation so a reissued destination ends up pending on its new owner.
  always_comb begin
    pend_d  = pend_q;
    owner_d = owner_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (pend_q[r] && clr_mask_i[owner_q[r]]) begin
        pend_d[r] = 1'b0;
      end else begin
        pend_d[r] = pend_q[r];
      end
      // x0 is hardwired zero and never waits on a producer.
      if (set_en_i && (set_reg_i == RW'(r)) && (r != 0)) begin
        pend_d[r]  = 1'b1;
        owner_d[r] = set_owner_i;
      end else begin
        owner_d[r] = owner_q[r];
      end
    end
  end

  // Scoreboard state registers; reset abandons all outstanding tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        owner_q[r] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end

  // Hazard reads see registered state only; no bypass from this cycle's done.
  assign rs1_pend_o = pend_q[rs1_i];
  assign rs2_pend_o = pend_q[rs2_i];
  assign rd_pend_o  = pend_q[rd_i];

endmodule

// File: rtl/issue_ctrl.sv
// In-order single-issue controller: checks structural, RAW and WAW hazards
// for the queue head, tracks unit occupancy and drains in-flight work after
// a branch mispredict while the writeback stage squashes results.
module issue_ctrl
  import rv32i_types::*;
#(
  parameter int NUM_FU   = FU_COUNT,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iq_empty,
  input  iq_entry_t         iq_head,
  output logic              iq_deq,
  input  logic [NUM_FU-1:0] fu_ready,
  output logic [NUM_FU-1:0] fu_issue,
  output iq_entry_t         fu_issue_data,
  input  logic [NUM_FU-1:0] fu_done,
  input  logic              flush,
  output logic              wb_squash,
  output logic [31:0]       stall_cycles
);

  localparam int OW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int RW = $clog2(NUM_REGS);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [NUM_FU-1:0] busy_q;
  logic [NUM_FU-1:0] busy_d;
  logic [31:0]       stall_q;
  logic [31:0]       stall_d;

  logic [OW-1:0]     tgt_s;
  logic [NUM_FU-1:0] done_eff_s;
  logic [NUM_FU-1:0] issue_oh_s;
  logic              rs1_pend_s;
  logic              rs2_pend_s;
  logic              rd_pend_s;
  logic              hazard_s;
  logic              issue_s;

  assign tgt_s = OW'(iq_head.fu_type);

  // Completion on an idle unit carries no information and is dropped.
  assign done_eff_s = fu_done & busy_q;

  reg_status_table #(
    .NUM_REGS (NUM_REGS),
    .NUM_FU   (NUM_FU)
  ) u_rst (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (issue_s && iq_head.writes_rd && (iq_head.rd != 5'd0)),
    .set_reg_i   (iq_head.rd[RW-1:0]),
    .set_owner_i (tgt_s),
    .clr_mask_i  (done_eff_s),
    .rs1_i       (iq_head.rs1[RW-1:0]),
    .rs2_i       (iq_head.rs2[RW-1:0]),
    .rd_i        (iq_head.rd[RW-1:0]),
    .rs1_pend_o  (rs1_pend_s),
    .rs2_pend_o  (rs2_pend_s),
    .rd_pend_o   (rd_pend_s)
  );

  // Issue decision for the head instruction; outputs are held low in reset.
  always_comb begin
    hazard_s = (iq_head.uses_rs1  && rs1_pend_s) ||
               (iq_head.uses_rs2  && rs2_pend_s) ||
               (iq_head.writes_rd && rd_pend_s);
    if (!rst && (state_q == ST_RUN) && !iq_empty && !flush &&
        fu_ready[tgt_s] && !busy_q[tgt_s] && !hazard_s) begin
      issue_s    = 1'b1;
      issue_oh_s = {{(NUM_FU-1){1'b0}}, 1'b1} << tgt_s;
    end else begin
      issue_s    = 1'b0;
      issue_oh_s = '0;
    end
  end

  // Unit occupancy: completion frees a unit, a same-cycle issue re-claims it.
  always_comb begin
    busy_d = (busy_q & ~done_eff_s) | issue_oh_s;
  end

  // RUN/DRAIN sequencing; DRAIN lasts until every unit has gone idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (busy_d == '0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Head-blocked cycle counter, saturating at its maximum value.
  always_comb begin
    if ((state_q == ST_RUN) && !iq_empty && !issue_s && !flush &&
        (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      busy_q  <= '0;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign iq_deq        = issue_s;
  assign fu_issue      = issue_oh_s;
  assign fu_issue_data = iq_head;
  assign wb_squash     = !rst && (state_q == ST_DRAIN);
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hand-computed issue timing, hazard blocking,
// drain/squash windows, counter values and asynchronous reset behaviour.
module tb_issue_ctrl;
  import rv32i_types::*;

  logic        clk;
  logic        rst;
  logic        iq_empty;
  iq_entry_t   iq_head;
  logic        iq_deq;
  logic [3:0]  fu_ready;
  logic [3:0]  fu_issue;
  iq_entry_t   fu_issue_data;
  logic [3:0]  fu_done;
  logic        flush;
  logic        wb_squash;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  issue_ctrl #(
    .NUM_FU   (4),
    .NUM_REGS (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .iq_empty      (iq_empty),
    .iq_head       (iq_head),
    .iq_deq        (iq_deq),
    .fu_ready      (fu_ready),
    .fu_issue      (fu_issue),
    .fu_issue_data (fu_issue_data),
    .fu_done       (fu_done),
    .flush         (flush),
    .wb_squash     (wb_squash),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue one-hot plus the matching dequeue strobe.
  task automatic expect_issue(input string tag, input logic [3:0] oh);
    check({tag, "_iss"}, 64'(fu_issue), 64'(oh));
    check({tag, "_deq"}, 64'(iq_deq), 64'(|oh));
  endtask

  function automatic iq_entry_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic u1,
                                   input logic u2, input logic w, input fu_type_e fu);
    iq_entry_t e;
    e.rd        = rd;
    e.rs1       = rs1;
    e.rs2       = rs2;
    e.uses_rs1  = u1;
    e.uses_rs2  = u2;
    e.writes_rd = w;
    e.fu_type   = fu;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  iq_entry_t e;

  initial begin
    rst      = 1'b1;
    iq_empty = 1'b0;
    iq_head  = mk(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, FU_ALU);
    fu_ready = 4'hF;
    fu_done  = 4'h0;
    flush    = 1'b0;

    // Reset: nothing issues even though the head looks issuable.
    @(negedge clk);
    expect_issue("rst", 4'b0000);
    check("rst_squash", 64'(wb_squash), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    @(posedge clk);
    #1;
    iq_empty = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Independent ALU then MUL issue back to back.
    iq_empty = 1'b0;
    e = mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, FU_ALU);
    iq_head = e;
    @(negedge clk);
    expect_issue("b2b_c0", 4'b0001);
    check("b2b_c0_data", 64'(fu_issue_data), 64'(e));
    cyc();
    iq_head = mk(5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, FU_MUL);
    @(negedge clk);
    expect_issue("b2b_c1", 4'b0010);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0011;
    @(negedge clk);
    expect_issue("b2b_empty", 4'b0000);
    cyc();
    fu_done = 4'b0000;

    // ADD x5 then ADD x6,x5: blocked until the cycle after fu_done[0].
    iq_empty = 1'b0;
    iq_head = mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_ALU);
    @(negedge clk);
    expect_issue("raw_c0", 4'b0001);
    cyc();
    iq_head = mk(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, FU_ALU);
    @(negedge clk);
    expect_issue("raw_c1", 4'b0000);
    cyc();
    cyc();
    fu_done = 4'b0001;
    @(negedge clk);
    expect_issue("raw_nobypass", 4'b0000);
    cyc();
    fu_done = 4'b0000;
    @(negedge clk);
    expect_issue("raw_c4", 4'b0001);
    check("raw_stall", 64'(stall_cycles), 64'd3);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0001;
    cyc();
    fu_done = 4'b0000;

    // Two independent MULs: second waits for the unit, issues at cycle 4.
    iq_empty = 1'b0;
    iq_head = mk(5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_MUL);
    @(negedge clk);
    expect_issue("mul_c0", 4'b0010);
    cyc();
    iq_head = mk(5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, FU_MUL);
    @(negedge clk);
    expect_issue("mul_c1", 4'b0000);
    cyc();
    cyc();
    fu_done = 4'b0010;
    @(negedge clk);
    expect_issue("mul_c3", 4'b0000);
    cyc();
    fu_done = 4'b0000;
    @(negedge clk);
    expect_issue("mul_c4", 4'b0010);
    check("mul_stall", 64'(stall_cycles), 64'd6);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0010;
    cyc();
    fu_done = 4'b0000;

    // Cross-unit RAW through rs2: BR reading x10 waits for the ALU.
    iq_empty = 1'b0;
    iq_head = mk(5'd10, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, FU_ALU);
    @(negedge clk);
    expect_issue("rs2_c0", 4'b0001);
    cyc();
    iq_head = mk(5'd0, 5'd3, 5'd10, 1'b0, 1'b1, 1'b0, FU_BR);
    @(negedge clk);
    expect_issue("rs2_c1", 4'b0000);
    cyc();
    fu_done = 4'b0001;
    @(negedge clk);
    expect_issue("rs2_c2", 4'b0000);
    cyc();
    fu_done = 4'b0000;
    @(negedge clk);
    expect_issue("rs2_c3", 4'b1000);
    check("rs2_stall", 64'(stall_cycles), 64'd8);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b1000;
    cyc();
    fu_done = 4'b0000;

    // WAW: ALU writing x11 waits for the LSU that owns x11.
    iq_empty = 1'b0;
    iq_head = mk(5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_LSU);
    @(negedge clk);
    expect_issue("waw_c0", 4'b0100);
    cyc();
    iq_head = mk(5'd11, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1, FU_ALU);
    @(negedge clk);
    expect_issue("waw_c1", 4'b0000);
    cyc();
    fu_done = 4'b0100;
    @(negedge clk);
    expect_issue("waw_c2", 4'b0000);
    cyc();
    fu_done = 4'b0000;
    @(negedge clk);
    expect_issue("waw_c3", 4'b0001);
    check("waw_stall", 64'(stall_cycles), 64'd10);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0001;
    cyc();
    fu_done = 4'b0000;

    // Unit not ready blocks issue for one cycle.
    iq_empty = 1'b0;
    fu_ready = 4'b1110;
    iq_head = mk(5'd13, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_ALU);
    @(negedge clk);
    expect_issue("rdy_c0", 4'b0000);
    cyc();
    fu_ready = 4'hF;
    @(negedge clk);
    expect_issue("rdy_c1", 4'b0001);
    check("rdy_stall", 64'(stall_cycles), 64'd11);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0001;
    cyc();
    fu_done = 4'b0000;

    // Pending sources are ignored when the use flags are clear.
    iq_empty = 1'b0;
    iq_head = mk(5'd17, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_ALU);
    @(negedge clk);
    expect_issue("use_c0", 4'b0001);
    cyc();
    iq_head = mk(5'd18, 5'd17, 5'd17, 1'b0, 1'b0, 1'b1, FU_MUL);
    @(negedge clk);
    expect_issue("use_c1", 4'b0010);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0011;
    cyc();
    fu_done = 4'b0000;

    // Writing x0 never creates a dependence.
    iq_empty = 1'b0;
    iq_head = mk(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_ALU);
    @(negedge clk);
    expect_issue("x0_c0", 4'b0001);
    cyc();
    iq_head = mk(5'd14, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, FU_MUL);
    @(negedge clk);
    expect_issue("x0_c1", 4'b0010);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0011;
    cyc();
    fu_done = 4'b0000;

    // Flush with LSU busy on x7: squash cycles 3-5, RUN at 6, x7 released.
    iq_head = mk(5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_LSU);
    iq_empty = 1'b0;
    @(negedge clk);
    expect_issue("fl_c0", 4'b0100);
    cyc();
    iq_empty = 1'b1;
    cyc();
    iq_empty = 1'b0;
    iq_head = mk(5'd19, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, FU_ALU);
    flush = 1'b1;
    @(negedge clk);
    expect_issue("fl_c2", 4'b0000);
    check("fl_c2_squash", 64'(wb_squash), 64'd0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    expect_issue("fl_c3", 4'b0000);
    check("fl_c3_squash", 64'(wb_squash), 64'd1);
    cyc();
    @(negedge clk);
    check("fl_c4_squash", 64'(wb_squash), 64'd1);
    cyc();
    fu_done = 4'b0100;
    @(negedge clk);
    expect_issue("fl_c5", 4'b0000);
    check("fl_c5_squash", 64'(wb_squash), 64'd1);
    cyc();
    fu_done = 4'b0000;
    @(negedge clk);
    check("fl_c6_squash", 64'(wb_squash), 64'd0);
    expect_issue("fl_c6", 4'b0001);
    check("fl_stall", 64'(stall_cycles), 64'd11);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0001;
    cyc();
    fu_done = 4'b0000;

    // Flush while idle, repeated in DRAIN: one DRAIN cycle after the last flush.
    flush = 1'b1;
    @(negedge clk);
    check("idle_c0_squash", 64'(wb_squash), 64'd0);
    cyc();
    @(negedge clk);
    check("idle_c1_squash", 64'(wb_squash), 64'd1);
    cyc();
    flush = 1'b0;
    iq_empty = 1'b0;
    iq_head = mk(5'd20, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_ALU);
    @(negedge clk);
    check("idle_c2_squash", 64'(wb_squash), 64'd1);
    expect_issue("idle_c2", 4'b0000);
    cyc();
    @(negedge clk);
    check("idle_c3_squash", 64'(wb_squash), 64'd0);
    expect_issue("idle_c3", 4'b0001);
    check("idle_stall", 64'(stall_cycles), 64'd11);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0001;
    cyc();
    fu_done = 4'b0000;

    // Asynchronous reset mid-DRAIN with the ALU busy on x15.
    iq_empty = 1'b0;
    iq_head = mk(5'd15, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, FU_ALU);
    @(negedge clk);
    expect_issue("ar_c0", 4'b0001);
    cyc();
    iq_empty = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    iq_empty = 1'b0;
    e = mk(5'd16, 5'd15, 5'd0, 1'b1, 1'b0, 1'b1, FU_ALU);
    iq_head = e;
    @(negedge clk);
    check("ar_pre_squash", 64'(wb_squash), 64'd1);
    expect_issue("ar_pre", 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    check("ar_squash", 64'(wb_squash), 64'd0);
    check("ar_stall", 64'(stall_cycles), 64'd0);
    expect_issue("ar_in", 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_issue("ar_post", 4'b0001);
    check("ar_post_data", 64'(fu_issue_data), 64'(e));
    check("ar_post_squash", 64'(wb_squash), 64'd0);
    cyc();
    iq_empty = 1'b1;
    fu_done  = 4'b0001;
    cyc();
    fu_done = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, meaning number of functional units (ALU=0, MUL=1, LSU=2, BR=3).
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning architectural registers tracked.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 iq_empty  input  1  instruction queue empty.
REQ-006 iq_head  input  iq_entry_t  instruction at queue head.
REQ-007 iq_deq  output  1  dequeue strobe to instruction queue.
REQ-008 fu_ready  input  NUM_FU  unit can accept an instruction this cycle.
REQ-009 fu_issue  output  NUM_FU  one-hot issue strobe per unit.
REQ-010 fu_issue_data  output  iq_entry_t  issued instruction, shared by all units.
REQ-011 fu_done  input  NUM_FU  unit finished its instruction this cycle.
REQ-012 flush  input  1  branch mispredict; squash younger work.
REQ-013 wb_squash  output  1  writeback stage discards results while high.
REQ-014 stall_cycles  output  32  performance counter of head-blocked cycles.

Function
REQ-015 SHALL keep fu_busy[NUM_FU] and per-register pending bit plus owner FU index.
REQ-016 Issue condition: state RUN, !iq_empty, !flush, fu_ready[t], !fu_busy[t], where t = iq_head.fu_type.
REQ-017 RAW hazard: issue SHALL block if uses_rs1/uses_rs2 and pending[rs1]/pending[rs2].
REQ-018 WAW hazard: issue SHALL block if writes_rd and pending[rd].
REQ-019 Hazard checks SHALL use registered pending state only; no same-cycle bypass from fu_done.
REQ-020 When issue condition holds, iq_deq and fu_issue[t] SHALL assert combinationally in the same cycle; fu_issue_data = iq_head.
REQ-021 At most one instruction issues per cycle; in-order, head only.
REQ-022 On issue, next edge: fu_busy[t]=1; if writes_rd and rd!=0, pending[rd]=1, owner[rd]=t.
REQ-023 Register x0 SHALL never become pending.
REQ-024 On fu_done[u], next edge: fu_busy[u]=0; every register with owner u and pending SHALL clear.
REQ-025 fu_done[u] and issue to u in same cycle: fu_busy[u] stays 1; the done-clear applies only to the old owner's register, new rd set pending.
REQ-026 fu_done on a unit not busy SHALL be ignored.
REQ-027 FSM states RUN, DRAIN; reset state RUN.
REQ-028 RUN -> DRAIN on flush; no issue that cycle.
REQ-029 DRAIN: no issue; wb_squash=1; fu_done clears busy/pending as in REQ-024.
REQ-030 DRAIN -> RUN on the edge after which all fu_busy are 0 (including done arriving that cycle); flush in DRAIN stays DRAIN.
REQ-031 flush with all units idle SHALL still spend exactly one cycle in DRAIN.
REQ-032 stall_cycles SHALL increment by 1 each RUN cycle with !iq_empty and !iq_deq and !flush; saturates at 2^32-1.

Reset
REQ-033 rst SHALL asynchronously force: state RUN, fu_busy all 0, pending all 0, owners 0, stall_cycles 0.
REQ-034 During and after reset: iq_deq=0, fu_issue=0, wb_squash=0 until conditions of REQ-016 hold.
REQ-035 Reset mid-DRAIN or mid-hazard SHALL abandon all tracking without waiting for fu_done.

Structure
REQ-036 rv32i_types SHALL hold iq_entry_t fields rd, rs1, rs2, uses_rs1, uses_rs2, writes_rd, fu_type, and fu_type_e enum plus NUM_FU constant.
REQ-037 One sub-module reg_status_table (pending/owner array, set port, clear-by-owner port, two read ports plus rd read) is natural; FSM and counter stay in issue_ctrl.

Verification
REQ-038 ADD x5 to ALU then ADD x6,x5 at head -> first issues cycle 0, second blocked until cycle after fu_done[0], stall_cycles counts the gap.
REQ-039 ADD x1 (ALU), MUL x2 (MUL) back-to-back, no dependence, all ready -> issue cycles 0 and 1, fu_issue 4'b0001 then 4'b0010.
REQ-040 Two MULs independent, fu_done[1] at cycle 3 -> second MUL issues cycle 4, not earlier.
REQ-041 LSU busy writing x7, flush at cycle 2, fu_done[2] cycle 5 -> wb_squash high cycles 3-5, RUN cycle 6, pending[7]=0.
REQ-042 Instruction writing x0 issued -> pending[0] stays 0; following reader of x0 issues next cycle.
REQ-043 rst asserted asynchronously mid-DRAIN with ALU busy -> all outputs 0 immediately, next head issues first cycle after release.
